funnel_dat_1_5: RTL

- Transmit-side counterpart of the defunnel stage: accepts one 1024-bit word (eight 128-bit slots) and serialises it onto up to four 128-bit lanes over several beats.
- The config byte selects the lane count per beat: 1, 2 or 4 lanes, giving 8, 4 or 2 beats per word.
- Sits between a wide datapath producer and the narrow lane fabric that later feeds the defunnel on the far side.
- Req/ack handshake on both sides. A word is captured into a local buffer and beats are issued from it.

---
 rtl/funnel_dat_1_5.sv | 101 ++++++++++
 1 files changed

// File: rtl/funnel_dat_1_5.sv
// rtl/funnel_dat_1_5.sv - serialises one 1024-bit word (eight slots) onto 1, 2 or 4 lanes over several beats
// Word captured into a local buffer in IDLE (or on the last beat), beats issued from it in SEND.
module funnel_dat_1_5 #(
   parameter int LANE_W = 128
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [8*LANE_W-1:0]   t_0_dat,
   input  logic [7:0]            t_cfg_dat,
   input  logic                  t_0_req,
   output logic                  t_0_ack,
   output logic [LANE_W-1:0]     i_0_dat,
   output logic [LANE_W-1:0]     i_1_dat,
   output logic [LANE_W-1:0]     i_2_dat,
   output logic [LANE_W-1:0]     i_3_dat,
   output logic [7:0]            i_cfg_dat,
   output logic                  i_last,
   output logic                  i_req,
   input  logic                  i_ack
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state, state_next;
   logic [8*LANE_W-1:0]   buf_q;
   logic [7:0]            cfg_q;
   logic [2:0]            k;
   logic [1:0]            lsh;
   logic [3:0]            lane_en;
   logic [2:0]            last_k;
   logic [2:0]            base;
   logic                  capture;
   logic [LANE_W-1:0]     slot [8];
   logic [LANE_W-1:0]     lane [4];

   // Unlisted reduct codes fall back to single-lane operation.
   always_comb begin
      lsh     = 2'd0;
      lane_en = 4'b0001;
      last_k  = 3'd7;
      case (cfg_q[2:0])
         3'd2: begin lsh = 2'd1; lane_en = 4'b0011; last_k = 3'd3; end
         3'd4: begin lsh = 2'd2; lane_en = 4'b1111; last_k = 3'd1; end
         default: ;
      endcase
   end

   assign i_req     = (state == SEND);
   assign i_last    = (state == SEND) && (k == last_k);
   assign t_0_ack   = (state == IDLE) || (i_last && i_ack);
   assign capture   = t_0_req && t_0_ack;
   assign i_cfg_dat = cfg_q;
   assign base      = k << lsh;

   always_comb begin
      for (int s = 0; s < 8; s++) begin
         slot[s] = buf_q[s*LANE_W +: LANE_W];
      end
      for (int j = 0; j < 4; j++) begin
         lane[j] = (i_req && lane_en[j]) ? slot[base + 3'(j)] : '0;
      end
   end

   assign i_0_dat = lane[0];
   assign i_1_dat = lane[1];
   assign i_2_dat = lane[2];
   assign i_3_dat = lane[3];

   always_comb begin
      state_next = state;
      if (capture) begin
         state_next = SEND;
      end else if (i_last && i_ack) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Counter only advances on a non-final accepted beat; the final beat reloads or idles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q <= '0;
         cfg_q <= '0;
         k     <= '0;
      end else if (capture) begin
         buf_q <= t_0_dat;
         cfg_q <= t_cfg_dat;
         k     <= '0;
      end else if (i_req && i_ack && !i_last) begin
         k     <= k + 3'd1;
      end
   end

endmodule
